// File: rtl/poly_sum.sv
// poly_sum: downstream combiner for the polyphase decimating FIR.
// Snapshots the M bank outputs on start, sums them serially through a
// single adder, rounds half-up, saturates to OUTPUT_WIDTH and offers the
// result on a valid/ready handshake.
module poly_sum #(
    parameter int M            = 20,
    parameter int IN_WIDTH     = 35,
    parameter int ACC_WIDTH    = 40,
    parameter int SHIFT        = 21,
    parameter int OUTPUT_WIDTH = 14
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [M*IN_WIDTH-1:0]          din_bus,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic                           dout_sat,
    output logic                           busy,
    output logic                           overrun
);

    localparam int IDX_W     = (M > 1) ? $clog2(M) : 1;
    localparam int ROUND_BIT = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(M - 1);

    // Half an output LSB, added before the shift; zero when no bits are dropped.
    localparam logic signed [ACC_WIDTH:0] ROUND_CONST =
        (SHIFT > 0) ? ((ACC_WIDTH + 1)'(1) << ROUND_BIT) : '0;

    // Output range limits expressed at the widened rounding width.
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        {{(ACC_WIDTH + 2 - OUTPUT_WIDTH){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN =
        {{(ACC_WIDTH + 2 - OUTPUT_WIDTH){1'b1}}, {(OUTPUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUM   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [IN_WIDTH-1:0]  snapshot [M];
    logic signed [ACC_WIDTH-1:0] acc;
    logic [IDX_W-1:0]            index;

    logic                           take_start;
    logic                           drop_start;
    logic signed [ACC_WIDTH-1:0]    term;
    logic signed [ACC_WIDTH:0]      acc_wide;
    logic signed [ACC_WIDTH:0]      rounded;
    logic signed [OUTPUT_WIDTH-1:0] round_out;
    logic                           round_sat;

    assign dout_valid = (state == OUT);
    assign busy       = (state != IDLE);

    // State register; reset wins over everything and abandons any sum in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; also decides whether this cycle's start is taken or dropped.
    always_comb begin
        next_state = state;
        take_start = 1'b0;
        drop_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    take_start = 1'b1;
                    next_state = SUM;
                end
            end
            SUM: begin
                drop_start = start;
                if (index == LAST_INDEX) begin
                    next_state = ROUND;
                end
            end
            ROUND: begin
                drop_start = start;
                next_state = OUT;
            end
            OUT: begin
                if (dout_ready) begin
                    if (start) begin
                        take_start = 1'b1;
                        next_state = SUM;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    drop_start = start;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Snapshot of the bank outputs, so the banks are free to start the next period.
    always_ff @(posedge clk) begin
        if (take_start) begin
            for (int k = 0; k < M; k++) begin
                snapshot[k] <= din_bus[k*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // Sign-extend the bank currently selected for accumulation.
    always_comb begin
        term = ACC_WIDTH'(snapshot[index]);
    end

    // Round half-up and saturate; the extra bit keeps the rounding add from wrapping.
    always_comb begin
        acc_wide  = {acc[ACC_WIDTH-1], acc};
        rounded   = (acc_wide + ROUND_CONST) >>> SHIFT;
        round_out = rounded[OUTPUT_WIDTH-1:0];
        round_sat = 1'b0;
        if (rounded > OUT_MAX) begin
            round_out = OUT_MAX[OUTPUT_WIDTH-1:0];
            round_sat = 1'b1;
        end else if (rounded < OUT_MIN) begin
            round_out = OUT_MIN[OUTPUT_WIDTH-1:0];
            round_sat = 1'b1;
        end
    end

    // Accumulator, bank index, output register and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            index    <= '0;
            dout     <= '0;
            dout_sat <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (take_start) begin
                acc   <= '0;
                index <= '0;
            end else if (state == SUM) begin
                acc <= acc + term;
                if (index != LAST_INDEX) begin
                    index <= index + IDX_W'(1);
                end
            end
            if (state == ROUND) begin
                dout     <= round_out;
                dout_sat <= round_sat;
            end
            if (drop_start) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_poly_sum.sv
// tb_poly_sum: table-driven, randomized and hand-sequenced checks of poly_sum.
module tb_poly_sum;

    localparam int M            = 20;
    localparam int IN_WIDTH     = 35;
    localparam int ACC_WIDTH    = 40;
    localparam int SHIFT        = 21;
    localparam int OUTPUT_WIDTH = 14;
    localparam int MAX_WAIT     = 100;

    logic                           clk;
    logic                           rst_n;
    logic                           start;
    logic [M*IN_WIDTH-1:0]          din_bus;
    logic signed [OUTPUT_WIDTH-1:0] dout;
    logic                           dout_valid;
    logic                           dout_ready;
    logic                           dout_sat;
    logic                           busy;
    logic                           overrun;

    int tests;
    int failures;

    typedef struct {
        string  name;
        longint first;
        longint fill;
        longint exp_dout;
        bit     exp_sat;
    } vec_t;

    vec_t vecs [10];

    poly_sum #(
        .M(M), .IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH),
        .SHIFT(SHIFT), .OUTPUT_WIDTH(OUTPUT_WIDTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .din_bus(din_bus),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_sat(dout_sat),
        .busy(busy),
        .overrun(overrun)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint actual, input longint expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: round half-up on the exact sum, then clamp to the output range.
    task automatic model(input longint sum, output longint d, output bit s);
        longint r;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (OUTPUT_WIDTH - 1)) - 1;
        lo = -(longint'(1) <<< (OUTPUT_WIDTH - 1));
        r  = (sum + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        s  = 1'b0;
        d  = r;
        if (r > hi) begin d = hi; s = 1'b1; end
        if (r < lo) begin d = lo; s = 1'b1; end
    endtask

    function automatic logic [M*IN_WIDTH-1:0] build_bus(input longint first, input longint fill);
        logic [M*IN_WIDTH-1:0] bus;
        longint v;
        bus = '0;
        for (int k = 0; k < M; k++) begin
            v = (k == 0) ? first : fill;
            bus[k*IN_WIDTH +: IN_WIDTH] = v[IN_WIDTH-1:0];
        end
        return bus;
    endfunction

    task automatic scramble_bus();
        for (int k = 0; k < M*IN_WIDTH; k += 32) begin
            din_bus[k +: 32] = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send_start(input logic [M*IN_WIDTH-1:0] bus);
        din_bus = bus;
        start   = 1'b1;
        step();
        start = 1'b0;
        scramble_bus();
    endtask

    // Counts cycles from the start edge until dout_valid, watching busy along the way.
    task automatic wait_valid(output int cycles, output bit busy_ok);
        cycles  = 0;
        busy_ok = 1'b1;
        while (!dout_valid && cycles < MAX_WAIT) begin
            if (!busy) busy_ok = 1'b0;
            step();
            cycles++;
        end
    endtask

    task automatic applyStimulus(input string name, input logic [M*IN_WIDTH-1:0] bus,
                                 input longint exp_d, input bit exp_s);
        int cycles;
        bit busy_ok;
        dout_ready = 1'b1;
        send_start(bus);
        wait_valid(cycles, busy_ok);
        checkOutput(name, cycles, busy_ok, exp_d, exp_s);
    endtask

    task automatic checkOutput(input string name, input int cycles, input bit busy_ok,
                               input longint exp_d, input bit exp_s);
        check({name, "_latency"}, cycles, M + 1);
        check({name, "_busy"}, busy_ok, 1);
        check({name, "_dout"}, longint'(dout), exp_d);
        check({name, "_sat"}, dout_sat, exp_s);
        step();
        check({name, "_valid_drop"}, dout_valid, 0);
        check({name, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [M*IN_WIDTH-1:0] bus;
        longint sum;
        longint v;
        longint exp_d;
        bit exp_s;
        int cycles;
        bit busy_ok;
        bit stable;
        int e;

        tests      = 0;
        failures   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        dout_ready = 1'b0;
        din_bus    = '0;

        vecs[0] = '{"basic",        longint'(1) <<< 21,       longint'(1) <<< 21,  20,    1'b0};
        vecs[1] = '{"half_up",      longint'(1) <<< 20,       0,                   1,     1'b0};
        vecs[2] = '{"below_half",   (longint'(1) <<< 20) - 1, 0,                   0,     1'b0};
        vecs[3] = '{"neg_half",     -(longint'(1) <<< 20),    0,                   0,     1'b0};
        vecs[4] = '{"neg_over",     -(longint'(1) <<< 20) - 1, 0,                  -1,    1'b0};
        vecs[5] = '{"sat_pos",      longint'(1) <<< 30,       longint'(1) <<< 30,  8191,  1'b1};
        vecs[6] = '{"sat_neg",      -(longint'(1) <<< 30),    -(longint'(1) <<< 30), -8192, 1'b1};
        vecs[7] = '{"max_exact",    longint'(8191) <<< 21,    0,                   8191,  1'b0};
        vecs[8] = '{"min_exact",    -(longint'(8192) <<< 21), 0,                   -8192, 1'b0};
        vecs[9] = '{"round_to_sat", (longint'(8191) <<< 21) + (longint'(1) <<< 20), 0, 8191, 1'b1};

        do_reset();
        check("reset_dout", longint'(dout), 0);
        check("reset_valid", dout_valid, 0);
        check("reset_sat", dout_sat, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);

        // Table of fixed vectors.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].name, build_bus(vecs[i].first, vecs[i].fill),
                          vecs[i].exp_dout, vecs[i].exp_sat);
        end

        // Randomized vectors against the reference model.
        for (int i = 0; i < 25; i++) begin
            sum = 0;
            bus = '0;
            for (int k = 0; k < M; k++) begin
                e = (i % 4 == 0) ? 33 : ((i % 4 == 1) ? 30 : ((i % 4 == 2) ? 26 : 20));
                v = longint'({$urandom, $urandom}) % (longint'(1) <<< e);
                bus[k*IN_WIDTH +: IN_WIDTH] = v[IN_WIDTH-1:0];
                sum += v;
            end
            model(sum, exp_d, exp_s);
            applyStimulus($sformatf("rand%0d", i), bus, exp_d, exp_s);
        end
        check("no_overrun_yet", overrun, 0);

        // Start during SUM is dropped, then backpressure holds the result.
        dout_ready = 1'b0;
        send_start(build_bus(longint'(1) <<< 21, longint'(1) <<< 21));
        step();
        step();
        check("sum_pre_overrun", overrun, 0);
        start   = 1'b1;
        din_bus = build_bus(longint'(1) <<< 22, longint'(1) <<< 22);
        step();
        start = 1'b0;
        check("sum_overrun", overrun, 1);
        wait_valid(cycles, busy_ok);
        check("sum_start_ignored_dout", longint'(dout), 20);
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (!dout_valid || dout !== 14'sd20) stable = 1'b0;
        end
        check("backpressure_stable", stable, 1);

        // Start in OUT without handshake is dropped too.
        do_reset();
        check("overrun_cleared", overrun, 0);
        dout_ready = 1'b0;
        send_start(build_bus(longint'(1) <<< 21, longint'(1) <<< 21));
        wait_valid(cycles, busy_ok);
        start   = 1'b1;
        din_bus = build_bus(longint'(1) <<< 22, longint'(1) <<< 22);
        step();
        start = 1'b0;
        check("out_overrun", overrun, 1);
        check("out_dout_held", longint'(dout), 20);
        check("out_valid_held", dout_valid, 1);
        dout_ready = 1'b1;
        step();
        check("out_release_valid", dout_valid, 0);
        check("out_release_busy", busy, 0);

        // Back-to-back: handshake and start in the same cycle.
        do_reset();
        dout_ready = 1'b0;
        send_start(build_bus(longint'(1) <<< 21, longint'(1) <<< 21));
        wait_valid(cycles, busy_ok);
        check("b2b_first_dout", longint'(dout), 20);
        dout_ready = 1'b1;
        send_start(build_bus(longint'(1) <<< 22, longint'(1) <<< 22));
        check("b2b_valid_drop", dout_valid, 0);
        check("b2b_busy", busy, 1);
        wait_valid(cycles, busy_ok);
        checkOutput("b2b_second", cycles, busy_ok, 40, 1'b0);
        check("b2b_overrun", overrun, 0);

        // Reset in the middle of SUM, with overrun set beforehand.
        send_start(build_bus(longint'(1) <<< 22, longint'(1) <<< 22));
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("mid_overrun_set", overrun, 1);
        for (int c = 3; c < 7; c++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_dout", longint'(dout), 0);
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_sat", dout_sat, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", overrun, 0);
        stable = 1'b1;
        for (int c = 0; c < M + 5; c++) begin
            step();
            if (dout_valid || busy) stable = 1'b0;
        end
        check("mid_rst_no_output", stable, 1);
        applyStimulus("after_rst", build_bus(longint'(1) <<< 21, longint'(1) <<< 21), 20, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
